// File: rtl/reg8_rr_write_arbiter_if.sv
// Write-port bundle for the round-robin shared-register arbiter.
// The requester side drives req/lock/wdata. The arbiter drives the grant,
// ack and register view.
interface reg8_rr_write_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int DW    = 8
);
  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    lock;
  logic [N_REQ*DW-1:0] wdata;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    ack;
  logic [DW-1:0]       q;
  logic                busy;
  logic [OW-1:0]       owner;

  // Requester side
  modport master (
    output req, lock, wdata,
    input  gnt, ack, q, busy, owner
  );

  // Arbiter side
  modport slave (
    input  req, lock, wdata,
    output gnt, ack, q, busy, owner
  );
endinterface

// File: rtl/reg8_rr_write_arbiter.sv
// Round-robin write arbiter in front of a single DW-bit holding register.
// A granted owner may keep the register for a locked burst of up to
// MAX_HOLD writes. After that burst the grant is always released so the
// other requesters get a turn.
// At re-arbitration the current owner is searched last, so it only wins
// again when nobody else is asking.
module reg8_rr_write_arbiter #(
  parameter int            N_REQ     = 4,
  parameter int            DW        = 8,
  parameter logic [DW-1:0] RESET_VAL = 8'h34,
  parameter int            MAX_HOLD  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  reg8_rr_write_arbiter_if.slave       bus
);

  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(MAX_HOLD + 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t           state_reg;
  logic [OW-1:0]    owner_reg;
  logic [CW-1:0]    cnt_reg;
  logic [N_REQ-1:0] gnt_reg;
  logic             busy_reg;
  logic [DW-1:0]    q_reg;

  logic [DW-1:0]    wdata_arr [N_REQ];
  logic [N_REQ-1:0] ack_vec;
  logic             any_req;
  logic [OW-1:0]    winner_next;
  logic [N_REQ-1:0] winner_onehot;
  logic             stay;

  // Unpack per-requester write data, and form the write-accept strobes.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_port
    assign wdata_arr[gi] = bus.wdata[gi*DW +: DW];
    assign ack_vec[gi]   = gnt_reg[gi] & bus.req[gi];
  end

  assign any_req = |bus.req;

  // The owner keeps the register only while it keeps requesting and
  // locking, and while the tenure is under the fairness cap.
  assign stay = bus.req[owner_reg] & bus.lock[owner_reg] &
                (cnt_reg < CW'(MAX_HOLD - 1));

  // Rotating priority search that starts just after the current owner.
  // The owner itself is the last candidate.
  always_comb begin
    logic          found;
    logic [OW-1:0] idx;
    winner_next = owner_reg;
    found       = 1'b0;
    idx         = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = OW'((int'(owner_reg) + k) % N_REQ);
      if (!found && bus.req[idx]) begin
        found       = 1'b1;
        winner_next = idx;
      end
    end
  end

  assign winner_onehot = N_REQ'(1) << winner_next;

  // Grant FSM, tenure counter and shared register. All of these are
  // registered, and reset wins over any write that is pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      owner_reg <= OW'(N_REQ - 1);
      cnt_reg   <= '0;
      gnt_reg   <= '0;
      busy_reg  <= 1'b0;
      q_reg     <= RESET_VAL;
    end else begin
      // ack is only ever set for the owner, so its data is the one written.
      if (|ack_vec) begin
        q_reg <= wdata_arr[owner_reg];
      end
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            state_reg <= GRANT;
            owner_reg <= winner_next;
            gnt_reg   <= winner_onehot;
            busy_reg  <= 1'b1;
            cnt_reg   <= '0;
          end
        end
        GRANT: begin
          if (stay) begin
            cnt_reg <= cnt_reg + CW'(1);
          end else if (any_req) begin
            // Hand over directly, with no idle cycle in between.
            owner_reg <= winner_next;
            gnt_reg   <= winner_onehot;
            busy_reg  <= 1'b1;
            cnt_reg   <= '0;
          end else begin
            // owner_reg keeps the last owner, so the next search is still fair.
            state_reg <= IDLE;
            gnt_reg   <= '0;
            busy_reg  <= 1'b0;
            cnt_reg   <= '0;
          end
        end
        default: begin
          state_reg <= IDLE;
          gnt_reg   <= '0;
          busy_reg  <= 1'b0;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  assign bus.gnt   = gnt_reg;
  assign bus.ack   = ack_vec;
  assign bus.q     = q_reg;
  assign bus.busy  = busy_reg;
  assign bus.owner = owner_reg;

endmodule

// File: tb/tb_reg8_rr_write_arbiter.sv
// Directed bench for reg8_rr_write_arbiter with N_REQ=4, DW=8, MAX_HOLD=4.
// Inputs change 1 ns after the rising edge. Outputs are checked 1 ns later.
module tb_reg8_rr_write_arbiter;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  reg8_rr_write_arbiter_if #(.N_REQ(4), .DW(8)) bus ();

  reg8_rr_write_arbiter #(
    .N_REQ(4), .DW(8), .RESET_VAL(8'h34), .MAX_HOLD(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks the registered view. It also checks that gnt is not multi-hot
  // and that busy follows gnt.
  task automatic chk_state(input string tag, input logic [3:0] e_gnt,
                           input logic [1:0] e_owner, input logic [7:0] e_q);
    chk({tag, ".gnt"},   32'(bus.gnt),   32'(e_gnt));
    chk({tag, ".busy"},  32'(bus.busy),  32'(e_gnt != 4'b0000));
    chk({tag, ".owner"}, 32'(bus.owner), 32'(e_owner));
    chk({tag, ".q"},     32'(bus.q),     32'(e_q));
    chk({tag, ".onehot"}, 32'($onehot0(bus.gnt)), 32'd1);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wdata(input int i, input logic [7:0] v);
    case (i)
      0: bus.wdata[7:0]   = v;
      1: bus.wdata[15:8]  = v;
      2: bus.wdata[23:16] = v;
      default: bus.wdata[31:24] = v;
    endcase
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    reset     = 1'b1;
    bus.req   = 4'b0000;
    bus.lock  = 4'b0000;
    bus.wdata = '0;

    // 1. Hold reset for two cycles, then release it with no requests.
    cyc();
    chk_state("rst0", 4'b0000, 2'd3, 8'h34);
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_state("idle", 4'b0000, 2'd3, 8'h34);
      $display("[TB] idle cycle %0d gnt=%b q=%h", i, bus.gnt, bus.q);
      cyc();
    end

    // 2. Single write by requester 0.
    bus.req = 4'b0001;
    set_wdata(0, 8'hA5);
    #1;
    chk("t2.ack_pre", 32'(bus.ack), 32'h0);
    chk("t2.gnt_pre", 32'(bus.gnt), 32'h0);
    cyc();
    chk_state("t2.grant", 4'b0001, 2'd0, 8'h34);
    chk("t2.ack", 32'(bus.ack), 32'h1);
    cyc();
    // Requester 0 is still the only request, so it is granted again.
    chk_state("t2.written", 4'b0001, 2'd0, 8'hA5);
    bus.req = 4'b0000;
    #1;
    chk("t2.ack_drop", 32'(bus.ack), 32'h0);
    cyc();
    chk_state("t2.idle", 4'b0000, 2'd0, 8'hA5);
    $display("[TB] single write q=%h gnt=%b", bus.q, bus.gnt);

    // 3. All four requesters, unlocked. Grants rotate one per cycle.
    bus.req = 4'b1111;
    for (int i = 0; i < 4; i++) set_wdata(i, 8'(8'h10 + i));
    #1;
    cyc();
    for (int i = 0; i < 6; i++) begin
      int o;
      o = (1 + i) % 4;
      chk("t3.gnt",   32'(bus.gnt),   32'(1 << o));
      chk("t3.ack",   32'(bus.ack),   32'(1 << o));
      chk("t3.owner", 32'(bus.owner), 32'(o));
      cyc();
      chk("t3.q", 32'(bus.q), 32'(8'h10 + o));
      $display("[TB] rr grant owner=%0d q=%h", o, bus.q);
    end
    bus.req = 4'b0000;
    #1;
    chk("t3.ack_drop", 32'(bus.ack), 32'h0);
    cyc();
    chk_state("t3.idle", 4'b0000, 2'd3, 8'h12);

    // 4. Locked burst by requester 2 while requester 1 waits.
    bus.req  = 4'b0100;
    bus.lock = 4'b0100;
    set_wdata(2, 8'hC0);
    #1;
    cyc();
    chk_state("t4.grant", 4'b0100, 2'd2, 8'h12);
    bus.req = 4'b0110;
    set_wdata(1, 8'hB1);
    for (int w = 0; w < 4; w++) begin
      set_wdata(2, 8'(8'hC0 + w));
      #1;
      chk("t4.gnt", 32'(bus.gnt), 32'h4);
      chk("t4.ack", 32'(bus.ack), 32'h4);
      cyc();
      chk("t4.q", 32'(bus.q), 32'(8'hC0 + w));
      $display("[TB] burst write %0d q=%h", w, bus.q);
    end
    chk_state("t4.handover", 4'b0010, 2'd1, 8'hC3);
    chk("t4.ack1", 32'(bus.ack), 32'h2);
    cyc();
    chk_state("t4.back2", 4'b0100, 2'd2, 8'hB1);

    // 5. Reset arrives in the middle of a burst (owner 2, cnt=1).
    set_wdata(2, 8'hD0);
    #1;
    cyc();
    chk_state("t5.cnt1", 4'b0100, 2'd2, 8'hD0);
    reset = 1'b1;
    set_wdata(2, 8'hD1);
    #1;
    cyc();
    chk_state("t5.reset", 4'b0000, 2'd3, 8'h34);
    reset = 1'b0;
    #1;
    chk("t5.ack_idle", 32'(bus.ack), 32'h0);
    cyc();
    chk_state("t5.regrant", 4'b0010, 2'd1, 8'h34);
    $display("[TB] after mid-burst reset owner=%0d", bus.owner);

    // 6. Owner drops req while locked. The grant moves on, and then goes idle.
    bus.lock = 4'b0010;
    set_wdata(1, 8'hE1);
    #1;
    chk("t6.ack", 32'(bus.ack), 32'h2);
    cyc();
    chk_state("t6.locked", 4'b0010, 2'd1, 8'hE1);
    bus.req = 4'b0100;
    set_wdata(1, 8'hEE);
    #1;
    chk("t6.ack_drop", 32'(bus.ack), 32'h0);
    cyc();
    chk_state("t6.pass", 4'b0100, 2'd2, 8'hE1);
    bus.req = 4'b0000;
    #1;
    chk("t6.ack_drop2", 32'(bus.ack), 32'h0);
    cyc();
    chk_state("t6.idle", 4'b0000, 2'd2, 8'hE1);
    $display("[TB] owner drop q=%h gnt=%b", bus.q, bus.gnt);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
